// File: rtl/main_mem_responder.sv
// Main-memory responder: byte-masked writes (command + data beat), fixed-latency tagged in-order reads.
// Optional build macro MEM_RESP_BACKPRESSURE_EN adds LFSR-driven ready throttling.
module main_mem_responder #(
  parameter int DATA_BITS  = 128,
  parameter int ADDR_BITS  = 28,
  parameter int TAG_BITS   = 5,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);

  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {IDLE = 1'b0, WDATA = 1'b1} state_t;

  state_t                  state_r, state_nxt_s;
  logic                    req_ready_r, data_ready_r;
  logic                    req_ready_nxt_s, data_ready_nxt_s;
  logic                    rd_fire_s, wr_fire_s, data_fire_s, gate_ok_s;
  logic [DEPTH_LOG2-1:0]   waddr_r, raddr_s;
  logic [DATA_BITS-1:0]    mem_r [DEPTH];
  logic [DATA_BITS-1:0]    bit_mask_s, wmerge_s;
  logic                    addr_unused_s;

  logic [LATENCY-1:0]      pipe_valid_r;
  logic [TAG_BITS-1:0]     pipe_tag_r  [LATENCY];
  logic [DATA_BITS-1:0]    pipe_data_r [LATENCY];

  function automatic logic [DATA_BITS-1:0] expand_mask(input logic [MASK_BITS-1:0] m);
    logic [DATA_BITS-1:0] r;
    r = '0;
    for (int b = 0; b < MASK_BITS; b++) begin
      r[b*8 +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

  // Upper address bits alias onto the same storage word.
  assign raddr_s       = mem_req_addr[DEPTH_LOG2-1:0];
  assign addr_unused_s = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

  assign rd_fire_s   = mem_req_valid & req_ready_r & ~mem_req_rw;
  assign wr_fire_s   = mem_req_valid & req_ready_r & mem_req_rw;
  assign data_fire_s = mem_req_data_valid & data_ready_r;

  assign bit_mask_s = expand_mask(mem_req_data_mask);
  assign wmerge_s   = (mem_r[waddr_r] & ~bit_mask_s) | (mem_req_data_bits & bit_mask_s);

`ifdef MEM_RESP_BACKPRESSURE_EN
  logic [7:0] lfsr_r, lfsr_nxt_s;

  assign lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  // Readies are registered, so gate on the LFSR value of the upcoming cycle.
  assign gate_ok_s  = (lfsr_nxt_s[1:0] != 2'b00);

  // Throttle LFSR, free-running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= lfsr_nxt_s;
    end
  end
`else
  assign gate_ok_s = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (wr_fire_s) state_nxt_s = WDATA;
        else           state_nxt_s = IDLE;
      end
      WDATA: begin
        if (data_fire_s) state_nxt_s = IDLE;
        else             state_nxt_s = WDATA;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode, computed for the next state so the readies can be registered.
  always_comb begin
    req_ready_nxt_s  = 1'b0;
    data_ready_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    req_ready_nxt_s  = gate_ok_s;
      WDATA:   data_ready_nxt_s = gate_ok_s;
      default: begin
        req_ready_nxt_s  = 1'b0;
        data_ready_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs and latched write address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r  <= 1'b0;
      data_ready_r <= 1'b0;
      waddr_r      <= '0;
    end else begin
      req_ready_r  <= req_ready_nxt_s;
      data_ready_r <= data_ready_nxt_s;
      if (wr_fire_s) waddr_r <= raddr_s;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (data_fire_s) mem_r[waddr_r] <= wmerge_s;
  end

  // Read delay pipe; the last stage drives the response, payload held while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag_r[i]  <= '0;
        pipe_data_r[i] <= '0;
      end
    end else begin
      pipe_valid_r[0] <= rd_fire_s;
      if (rd_fire_s) begin
        pipe_tag_r[0]  <= mem_req_tag;
        pipe_data_r[0] <= mem_r[raddr_s];
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_tag_r[i]  <= pipe_tag_r[i-1];
          pipe_data_r[i] <= pipe_data_r[i-1];
        end
      end
    end
  end

  assign mem_req_ready      = req_ready_r;
  assign mem_req_data_ready = data_ready_r;
  assign mem_resp_valid     = pipe_valid_r[LATENCY-1];
  assign mem_resp_tag       = pipe_tag_r[LATENCY-1];
  assign mem_resp_data      = pipe_data_r[LATENCY-1];

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: directed scenarios plus randomized traffic
// checked against a word-array reference model with per-response latency checking.
module tb_main_mem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic [4:0]   mem_req_tag;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [4:0]   mem_resp_tag;

  typedef struct {
    logic [4:0]   tag;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] model_mem [4096];
  logic [27:0]  wr_addr;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           ready_low_cnt = 0;

  main_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (!mem_req_ready) ready_low_cnt++;
      if (mem_resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: tag=%0d data=%h cycle=%0d, required no response",
                   mem_resp_tag, mem_resp_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (mem_resp_tag !== e.tag || mem_resp_data !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL resp: actual tag=%0d data=%h cycle=%0d, required tag=%0d data=%h cycle=%0d",
                     mem_resp_tag, mem_resp_data, cyc, e.tag, e.data, e.due);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_resp: actual none by cycle %0d, required tag=%0d at cycle %0d",
                 cyc, e.tag, e.due);
      end
    end else if (mem_resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_in_reset: actual valid=1, required 0");
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [127:0] model_rd(input logic [27:0] a);
    return model_mem[a[11:0]];
  endfunction

  function automatic void model_wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++) begin
      if (m[b]) model_mem[a[11:0]][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  // Issue one command at a negedge; leaves valid high so reads can go back-to-back.
  task automatic cmd(input logic rw, input logic [27:0] a, input logic [4:0] t);
    int w;
    exp_t e;
    w = 0;
    mem_req_valid = 1'b1;
    mem_req_rw    = rw;
    mem_req_addr  = a;
    mem_req_tag   = t;
    while (mem_req_ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: actual ready=%b after %0d cycles, required 1", mem_req_ready, w);
    end else if (!rw) begin
      e.tag  = t;
      e.data = model_rd(a);
      e.due  = cyc + LAT;
      exp_q.push_back(e);
    end else begin
      wr_addr = a;
    end
    @(negedge clk);
  endtask

  task automatic wdata(input logic [127:0] d, input logic [15:0] m);
    int w;
    w = 0;
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = d;
    mem_req_data_mask  = m;
    while (mem_req_data_ready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      errors++;
      $display("FAIL data_timeout: actual data_ready=%b, required 1", mem_req_data_ready);
    end else begin
      model_wr(wr_addr, d, m);
    end
    @(negedge clk);
    mem_req_data_valid = 1'b0;
  endtask

  task automatic write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    cmd(1'b1, a, 5'd0);
    wdata(d, m);
  endtask

  task automatic idle(input int n);
    mem_req_valid      = 1'b0;
    mem_req_data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int w;
    reset              = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = 28'd0;
    mem_req_tag        = 5'd0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = 128'd0;
    mem_req_data_mask  = 16'd0;
    wr_addr            = 28'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  128'(mem_req_ready), 128'(1'b0));
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'(1'b0));
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'(1'b0));
    chk("rst_resp_data",  mem_resp_data, 128'd0);
    chk("rst_resp_tag",   128'(mem_resp_tag), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(mem_req_ready), 128'(1'b1));

    // Test 1: masked overwrite
    write(28'h10, {16{8'h11}}, 16'hFFFF);
    write(28'h10, {16{8'hFF}}, 16'h000F);
    chk("t1_model", model_rd(28'h10), {{12{8'h11}}, 32'hFFFF_FFFF});
    cmd(1'b0, 28'h10, 5'd3);
    idle(LAT + 2);

    // Test 2: back-to-back reads
    write(28'h20, rnd128(), 16'hFFFF);
    cmd(1'b0, 28'h10, 5'd1);
    cmd(1'b0, 28'h20, 5'd2);
    idle(LAT + 2);

    // Test 3: stalled write data beat, then stray data beats in IDLE are ignored
    cmd(1'b1, 28'h30, 5'd0);
    mem_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_ready_low", 128'(mem_req_ready), 128'(1'b0));
      @(negedge clk);
    end
    wdata(rnd128(), 16'hFFFF);
`ifndef MEM_RESP_BACKPRESSURE_EN
    chk("t3_ready_after_data", 128'(mem_req_ready), 128'(1'b1));
`endif
    mem_req_data_valid = 1'b1;
    mem_req_data_bits  = rnd128();
    mem_req_data_mask  = 16'hFFFF;
    repeat (2) @(negedge clk);
    mem_req_data_valid = 1'b0;
    cmd(1'b0, 28'h30, 5'd7);
    idle(LAT + 2);

    // Test 4: reset with reads in flight
    cmd(1'b0, 28'h10, 5'd4);
    cmd(1'b0, 28'h20, 5'd5);
    cmd(1'b0, 28'h30, 5'd6);
    mem_req_valid = 1'b0;
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("t4_rst_resp_valid", 128'(mem_resp_valid), 128'(1'b0));
    chk("t4_rst_resp_data", mem_resp_data, 128'd0);
    chk("t4_rst_req_ready", 128'(mem_req_ready), 128'(1'b0));
    reset = 1'b1;
    idle(LAT + 4);
    cmd(1'b0, 28'h10, 5'd9);
    idle(LAT + 2);

    // Test 5: address aliasing
    write(28'h1010, rnd128(), 16'hFFFF);
    cmd(1'b0, 28'h0010, 5'd10);
    idle(LAT + 2);

    // Test 6: randomized traffic against the model
    for (int a = 0; a < 16; a++) write(28'h40 + 28'(a), rnd128(), 16'hFFFF);
    for (int n = 0; n < 1000; n++) begin
      logic [27:0] ra;
      ra = {16'($urandom_range(0, 65535)), 12'h040 + 12'($urandom_range(0, 15))};
      if ($urandom_range(0, 1) == 1) write(ra, rnd128(), 16'($urandom));
      else cmd(1'b0, ra, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);
    w = 0;
    while (exp_q.size() > 0 && w < LAT + 40) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", 128'(exp_q.size()), 128'd0);
    checks++;
    if (ready_low_cnt == 0) begin
      errors++;
      $display("FAIL ready_low_seen: actual count=0, required >0");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
